// File: rtl/imm_extend_if.sv
// imm_extend_if: instruction-in / immediate-out handshake bundle for imm_extend_pipe
interface imm_extend_if #(parameter int XLEN = 32);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [2:0]      in_immsrc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic            out_err;
  modport master (
    output flush, in_valid, in_instr, in_immsrc, out_ready,
    input  in_ready, out_valid, out_imm, out_err
  );
  modport slave (
    input  flush, in_valid, in_instr, in_immsrc, out_ready,
    output in_ready, out_valid, out_imm, out_err
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: one-cycle immediate extender behind a two-entry skid buffer
// Optional error counter enabled by macro IMM_EXTEND_ERR_CNT_EN.
module imm_extend_pipe #(
  parameter int XLEN = 32
) (
  input logic clk,
  input logic rst_n,
  imm_extend_if.slave bus
`ifdef IMM_EXTEND_ERR_CNT_EN
  ,
  output logic [15:0] err_count
`endif
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  logic [1:0]      state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic [XLEN-1:0] main_imm_q, main_imm_d, skid_imm_q, skid_imm_d, ext_imm;
  logic            main_err_q, main_err_d, skid_err_q, skid_err_d, ext_err;
  logic            accept, drain;
  logic            unused_opcode;
  assign unused_opcode = ^bus.in_instr[6:0];
  always_comb begin
    ext_imm = '0;
    case (bus.in_immsrc)
      3'b000:  ext_imm = XLEN'($signed(bus.in_instr[31:20]));
      3'b001:  ext_imm = XLEN'($signed({bus.in_instr[31:25], bus.in_instr[11:7]}));
      3'b010:  ext_imm = XLEN'($signed({bus.in_instr[31], bus.in_instr[7], bus.in_instr[30:25],
                                        bus.in_instr[11:8], 1'b0}));
      3'b011:  ext_imm = XLEN'($signed({bus.in_instr[31], bus.in_instr[19:12], bus.in_instr[20],
                                        bus.in_instr[30:21], 1'b0}));
      3'b100:  ext_imm = XLEN'($signed({bus.in_instr[31:12], 12'b0}));
      3'b101:  ext_imm = XLEN'(XLEN == 64 ? bus.in_instr[25:20] : {1'b0, bus.in_instr[24:20]});
      3'b110:  ext_imm = XLEN'(bus.in_instr[19:15]);
      default: ext_imm = '0;
    endcase
  end
  assign ext_err = bus.in_immsrc == 3'b111;
  assign accept  = bus.in_valid && in_ready_q;
  assign drain   = state_q != EMPTY && bus.out_ready;
  always_comb begin
    state_d    = state_q;
    main_imm_d = main_imm_q;
    main_err_d = main_err_q;
    skid_imm_d = skid_imm_q;
    skid_err_d = skid_err_q;
    if (bus.flush) state_d = EMPTY;
    else case (state_q)
      EMPTY: if (accept) begin
        state_d    = ONE;
        main_imm_d = ext_imm;
        main_err_d = ext_err;
      end
      ONE: if (accept && drain) begin
        main_imm_d = ext_imm;
        main_err_d = ext_err;
      end else if (accept) begin
        state_d    = FULL;
        skid_imm_d = ext_imm;
        skid_err_d = ext_err;
      end else if (drain) state_d = EMPTY;
      FULL: if (drain) begin
        state_d    = ONE;
        main_imm_d = skid_imm_q;
        main_err_d = skid_err_q;
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = state_d != FULL;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      main_imm_q <= '0;
      main_err_q <= 1'b0;
      skid_imm_q <= '0;
      skid_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_imm_q <= main_imm_d;
      main_err_q <= main_err_d;
      skid_imm_q <= skid_imm_d;
      skid_err_q <= skid_err_d;
    end
  end
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = state_q != EMPTY;
  assign bus.out_imm   = main_imm_q;
  assign bus.out_err   = main_err_q;
`ifdef IMM_EXTEND_ERR_CNT_EN
  logic [15:0] err_count_q, err_count_d;
  assign err_count_d = bus.flush ? 16'd0 :
                       (drain && main_err_q && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 :
                       err_count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count_q <= 16'd0;
    else        err_count_q <= err_count_d;
  end
  assign err_count = err_count_q;
`endif
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed checks of imm_extend_pipe at XLEN=32 and XLEN=64
module tb_imm_extend_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  imm_extend_if #(.XLEN(32)) b32 ();
  imm_extend_if #(.XLEN(64)) b64 ();
`ifdef IMM_EXTEND_ERR_CNT_EN
  logic [15:0] ec32, ec64;
  imm_extend_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32), .err_count(ec32));
  imm_extend_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64), .err_count(ec64));
`else
  imm_extend_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  imm_extend_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));
`endif
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic vec32(input string tag, input logic [31:0] ins, input logic [2:0] sel,
                       input logic [31:0] exp_imm, input logic exp_err);
    b32.in_valid = 1'b1; b32.in_instr = ins; b32.in_immsrc = sel;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    chk({tag, "_valid"}, 64'(b32.out_valid), 64'd1);
    chk({tag, "_imm"}, 64'(b32.out_imm), 64'(exp_imm));
    chk({tag, "_err"}, 64'(b32.out_err), 64'(exp_err));
  endtask
  task automatic vec64(input string tag, input logic [31:0] ins, input logic [2:0] sel,
                       input logic [63:0] exp_imm);
    b64.in_valid = 1'b1; b64.in_instr = ins; b64.in_immsrc = sel;
    @(posedge clk); #1;
    b64.in_valid = 1'b0;
    chk({tag, "_valid"}, 64'(b64.out_valid), 64'd1);
    chk({tag, "_imm"}, b64.out_imm, exp_imm);
  endtask
  initial begin
    b32.flush = 0; b32.in_valid = 0; b32.in_instr = 0; b32.in_immsrc = 0; b32.out_ready = 1;
    b64.flush = 0; b64.in_valid = 0; b64.in_instr = 0; b64.in_immsrc = 0; b64.out_ready = 1;
    #12;
    chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("rst_in_ready", 64'(b32.in_ready), 64'd0);
    chk("rst_out_imm", 64'(b32.out_imm), 64'd0);
    chk("rst_out_err", 64'(b32.out_err), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 64'(b32.in_ready), 64'd1);
    chk("rel_out_valid", 64'(b32.out_valid), 64'd0);
    vec32("i_neg1", 32'hFFF00093, 3'b000, 32'hFFFFFFFF, 1'b0);
    vec32("b_min", 32'h80000000, 3'b010, 32'hFFFFF000, 1'b0);
    vec32("j_min", 32'h80000000, 3'b011, 32'hFFF00000, 1'b0);
    vec32("u_pos", 32'h12345000, 3'b100, 32'h12345000, 1'b0);
    vec32("s_pos", 32'h00000F80, 3'b001, 32'h0000001F, 1'b0);
    vec32("s_min", 32'h80000000, 3'b001, 32'hFFFFF800, 1'b0);
    vec32("sh32", 32'h03F00000, 3'b101, 32'h0000001F, 1'b0);
    vec32("zimm32", 32'h000F8000, 3'b110, 32'h0000001F, 1'b0);
    vec32("illegal", 32'hFFFFFFFF, 3'b111, 32'h00000000, 1'b1);
    @(posedge clk); #1;
    chk("drained", 64'(b32.out_valid), 64'd0);
    vec64("sh64", 32'h03F00000, 3'b101, 64'h3F);
    vec64("zimm64", 32'h000F8000, 3'b110, 64'h1F);
    vec64("u64_neg", 32'h80000000, 3'b100, 64'hFFFFFFFF80000000);
    vec64("i64_neg1", 32'hFFF00093, 3'b000, 64'hFFFFFFFFFFFFFFFF);
    // backpressure: A and B fill main+skid, C waits until a slot frees
    b32.out_ready = 0;
    b32.in_valid = 1; b32.in_immsrc = 3'b000; b32.in_instr = 32'h00100093;
    @(posedge clk); #1;
    chk("bp_a_ready", 64'(b32.in_ready), 64'd1);
    chk("bp_a_imm", 64'(b32.out_imm), 64'd1);
    b32.in_instr = 32'h00200093;
    @(posedge clk); #1;
    chk("bp_full_ready", 64'(b32.in_ready), 64'd0);
    chk("bp_full_imm", 64'(b32.out_imm), 64'd1);
    b32.in_instr = 32'h00300093;
    @(posedge clk); #1;
    chk("bp_stall_ready", 64'(b32.in_ready), 64'd0);
    chk("bp_stall_imm", 64'(b32.out_imm), 64'd1);
    chk("bp_stall_valid", 64'(b32.out_valid), 64'd1);
    b32.out_ready = 1;
    @(posedge clk); #1;
    chk("bp_b_imm", 64'(b32.out_imm), 64'd2);
    chk("bp_b_ready", 64'(b32.in_ready), 64'd1);
    @(posedge clk); #1;
    b32.in_valid = 0;
    chk("bp_c_imm", 64'(b32.out_imm), 64'd3);
    chk("bp_c_valid", 64'(b32.out_valid), 64'd1);
    @(posedge clk); #1;
    chk("bp_empty", 64'(b32.out_valid), 64'd0);
    // flush while FULL with an input offered
    b32.out_ready = 0;
    b32.in_valid = 1; b32.in_instr = 32'h00500093;
    @(posedge clk); @(posedge clk); #1;
    chk("fl_full_ready", 64'(b32.in_ready), 64'd0);
    b32.flush = 1;
    @(posedge clk); #1;
    b32.flush = 0; b32.in_valid = 0;
    chk("fl_valid", 64'(b32.out_valid), 64'd0);
    chk("fl_ready", 64'(b32.in_ready), 64'd1);
    // flush in ONE discards the same-cycle accept
    b32.in_valid = 1;
    @(posedge clk); #1;
    chk("fl1_pre", 64'(b32.out_valid), 64'd1);
    b32.flush = 1;
    @(posedge clk); #1;
    b32.flush = 0; b32.in_valid = 0; b32.out_ready = 1;
    chk("fl1_valid", 64'(b32.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("fl1_nothing", 64'(b32.out_valid), 64'd0);
    // asynchronous reset mid-operation
    vec32("pre_rst", 32'h00700093, 3'b000, 32'd7, 1'b0);
    rst_n = 0; #1;
    chk("arst_valid", 64'(b32.out_valid), 64'd0);
    chk("arst_imm", 64'(b32.out_imm), 64'd0);
    chk("arst_ready", 64'(b32.in_ready), 64'd0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("arst_rel_ready", 64'(b32.in_ready), 64'd1);
`ifdef IMM_EXTEND_ERR_CNT_EN
    chk("ec_rst", 64'(ec32), 64'd0);
    vec32("ec_e1", 32'h0, 3'b111, 32'h0, 1'b1);
    vec32("ec_e2", 32'h12345678, 3'b111, 32'h0, 1'b1);
    vec32("ec_e3", 32'hFFFFFFFF, 3'b111, 32'h0, 1'b1);
    @(posedge clk); #1;
    chk("ec_three", 64'(ec32), 64'd3);
    rst_n = 0; #1;
    chk("ec_cleared", 64'(ec32), 64'd0);
    rst_n = 1;
    @(posedge clk); #1;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
